// File: rtl/ccr_ctrl.sv
// ccr_ctrl: condition-code register controller.
// Sets the external N/Z/P flops from the sign/zero of a bus word and
// evaluates branch masks against the current flop outputs.
// All state changes on the falling edge of clk; reset is synchronous, active-low.
//
// Ports
//   clk, reset           clock (falling-edge active), synchronous active-low reset
//   ld_cc, bus_in        load request pulse and the word whose sign/zero sets the codes
//   br_req, ir_nzp       branch request (level) and its {n,z,p} mask
//   ccr_n/z/p            current outputs of the external CCR flops
//   cc_in, cc_write      {N,Z,P} data and active-low write strobe to the CCR flops
//   busy                 FSM is not in IDLE
//   br_done, br_taken    one-cycle branch result
//   ld_overrun           sticky: a load request was dropped
//
// state | meaning
// INIT  | write INIT_CC to the flops after reset
// IDLE  | waiting; load has priority over branch
// CALC  | derive {N,Z,P} from data_q into cc_q
// WRITE | strobe cc_q into the flops for one cycle
// BR    | present branch result for one cycle
module ccr_ctrl #(
   parameter int         WIDTH   = 16,
   parameter logic [2:0] INIT_CC = 3'b010
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_cc,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             br_req,
   input  logic [2:0]       ir_nzp,
   input  logic             ccr_n,
   input  logic             ccr_z,
   input  logic             ccr_p,
   output logic [2:0]       cc_in,
   output logic             cc_write,
   output logic             busy,
   output logic             br_done,
   output logic             br_taken,
   output logic             ld_overrun
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_WRITE, S_BR} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] pend_data_q, pend_data_d;
   logic             pend_valid_q, pend_valid_d;
   logic [2:0]       cc_q, cc_d;
   logic [2:0]       cc_last_q, cc_last_d;
   logic [2:0]       nzp_q, nzp_d;
   logic             overrun_q, overrun_d;

   always_ff @(negedge clk) begin
      if (!reset) begin
         state_q      <= S_INIT;
         data_q       <= '0;
         pend_data_q  <= '0;
         pend_valid_q <= 1'b0;
         cc_q         <= 3'b000;
         cc_last_q    <= INIT_CC;
         nzp_q        <= 3'b000;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         pend_data_q  <= pend_data_d;
         pend_valid_q <= pend_valid_d;
         cc_q         <= cc_d;
         cc_last_q    <= cc_last_d;
         nzp_q        <= nzp_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      pend_data_d  = pend_data_q;
      pend_valid_d = pend_valid_q;
      cc_d         = cc_q;
      cc_last_d    = cc_last_q;
      nzp_d        = nzp_q;
      overrun_d    = overrun_q;
      case (state_q)
         S_INIT: state_d = S_IDLE;
         S_IDLE: begin
            // A load buffered during BR is drained before anything else so a
            // following branch always sees the newest flags.
            if (pend_valid_q) begin
               data_d  = pend_data_q;
               state_d = S_CALC;
               if (ld_cc) pend_data_d  = bus_in;
               else       pend_valid_d = 1'b0;
            end else if (ld_cc) begin
               data_d  = bus_in;
               state_d = S_CALC;
            end else if (br_req) begin
               nzp_d   = ir_nzp;
               state_d = S_BR;
            end
         end
         S_CALC: begin
            cc_d    = {data_q[WIDTH-1], data_q == '0, ~data_q[WIDTH-1] & (data_q != '0)};
            state_d = S_WRITE;
            if (ld_cc) begin
               if (!pend_valid_q) begin
                  pend_data_d  = bus_in;
                  pend_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            cc_last_d = cc_q;
            // WRITE chains straight into the next CALC when more work exists,
            // including a load arriving in this very cycle, so IDLE is never
            // entered with a pending update.
            if (pend_valid_q) begin
               data_d  = pend_data_q;
               state_d = S_CALC;
               if (ld_cc) pend_data_d  = bus_in;
               else       pend_valid_d = 1'b0;
            end else if (ld_cc) begin
               data_d  = bus_in;
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BR: begin
            state_d = S_IDLE;
            if (ld_cc) begin
               if (!pend_valid_q) begin
                  pend_data_d  = bus_in;
                  pend_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      cc_write   = ~((state_q == S_INIT) || (state_q == S_WRITE));
      br_done    = (state_q == S_BR);
      br_taken   = br_done & |(nzp_q & {ccr_n, ccr_z, ccr_p});
      ld_overrun = overrun_q;
      if (state_q == S_INIT)       cc_in = INIT_CC;
      else if (state_q == S_WRITE) cc_in = cc_q;
      else                         cc_in = cc_last_q;
   end

endmodule

// File: tb/tb_ccr_ctrl.sv
module tb_ccr_ctrl;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         ld_cc;
   logic [W-1:0] bus_in;
   logic         br_req;
   logic [2:0]   ir_nzp;
   logic         ccr_n = 1'b0, ccr_z = 1'b0, ccr_p = 1'b0;
   logic [2:0]   cc_in;
   logic         cc_write, busy, br_done, br_taken, ld_overrun;

   int n_cmp = 0;
   int n_err = 0;
   logic [2:0] exp_cc;

   ccr_ctrl #(.WIDTH(W), .INIT_CC(3'b010)) dut (
      .clk(clk), .reset(reset), .ld_cc(ld_cc), .bus_in(bus_in),
      .br_req(br_req), .ir_nzp(ir_nzp),
      .ccr_n(ccr_n), .ccr_z(ccr_z), .ccr_p(ccr_p),
      .cc_in(cc_in), .cc_write(cc_write), .busy(busy),
      .br_done(br_done), .br_taken(br_taken), .ld_overrun(ld_overrun)
   );

   always #5 clk = ~clk;

   // external CCR flops
   always @(negedge clk) if (cc_write === 1'b0) {ccr_n, ccr_z, ccr_p} <= cc_in;

   // reference classification: negative, zero, positive
   function automatic logic [2:0] cls(input logic [W-1:0] v);
      if (v == 0)               return 3'b010;
      else if ($signed(v) < 0)  return 3'b100;
      else                      return 3'b001;
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; ld_cc = 1'b0; br_req = 1'b0; bus_in = '0; ir_nzp = 3'b000;
      cyc(); cyc();
      reset = 1'b1;
      cyc();
      exp_cc = 3'b010;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 12) begin cyc(); k++; end
      if (busy !== 1'b0) begin
         n_cmp++; n_err++;
         $display("FAIL wait_idle: busy=%b expected 0 within 12 cycles", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; ld_cc = 1'b1; br_req = 1'b1; bus_in = 16'h8001; ir_nzp = 3'b111;
      cyc(); cyc();
      n_cmp++;
      if ({cc_write, cc_in, busy, br_done, br_taken, ld_overrun} !== {1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_outputs: wr=%b cc=%b busy=%b done=%b tk=%b ovr=%b expected 0 010 1 0 0 0",
                  cc_write, cc_in, busy, br_done, br_taken, ld_overrun);
      end
      reset = 1'b1;
      cyc();
      ld_cc = 1'b0; br_req = 1'b0;
      n_cmp++;
      if ({busy, cc_write} !== 2'b01) begin
         n_err++; $display("FAIL reset_release: busy=%b wr=%b expected busy=0 wr=1", busy, cc_write);
      end
      cyc();
      n_cmp++;
      if ({busy, ld_overrun, ccr_n, ccr_z, ccr_p} !== {1'b0, 1'b0, 3'b010}) begin
         n_err++; $display("FAIL init_ignored: busy=%b ovr=%b ccr=%b%b%b expected 0 0 010",
                           busy, ld_overrun, ccr_n, ccr_z, ccr_p);
      end
      exp_cc = 3'b010;
   endtask

   task automatic single_load(input logic [W-1:0] v, input string tag);
      wait_idle();
      bus_in = v; ld_cc = 1'b1;
      cyc();
      ld_cc = 1'b0; bus_in = $urandom;
      n_cmp++;
      if ({busy, cc_write} !== 2'b11) begin
         n_err++; $display("FAIL %s_calc: busy=%b wr=%b expected 1 1", tag, busy, cc_write);
      end
      cyc();
      n_cmp++;
      if ({cc_write, cc_in} !== {1'b0, cls(v)}) begin
         n_err++; $display("FAIL %s_write: wr=%b cc=%b expected 0 %b", tag, cc_write, cc_in, cls(v));
      end
      cyc();
      exp_cc = cls(v);
      n_cmp++;
      if ({cc_write, cc_in, ccr_n, ccr_z, ccr_p} !== {1'b1, exp_cc, exp_cc}) begin
         n_err++; $display("FAIL %s_hold: wr=%b cc=%b ccr=%b%b%b expected 1 %b %b",
                           tag, cc_write, cc_in, ccr_n, ccr_z, ccr_p, exp_cc, exp_cc);
      end
   endtask

   task automatic test_loads();
      single_load(16'h8001, "ld_neg");
      single_load(16'h0000, "ld_zero");
      single_load(16'h7FFF, "ld_pos");
   endtask

   task automatic branch(input logic [2:0] mask, input string tag);
      logic exp_t;
      wait_idle();
      exp_t = |(mask & exp_cc);
      br_req = 1'b1; ir_nzp = mask;
      cyc();
      br_req = 1'b0; ir_nzp = 3'($urandom);
      n_cmp++;
      if ({br_done, br_taken} !== {1'b1, exp_t}) begin
         n_err++; $display("FAIL %s: done=%b taken=%b expected 1 %b (mask %b flags %b)",
                           tag, br_done, br_taken, exp_t, mask, exp_cc);
      end
      cyc();
      n_cmp++;
      if ({br_done, br_taken, busy} !== 3'b000) begin
         n_err++; $display("FAIL %s_after: done=%b taken=%b busy=%b expected 000", tag, br_done, br_taken, busy);
      end
   endtask

   task automatic test_branch();
      single_load(16'h0000, "br_setz");
      branch(3'b010, "br_z_taken");
      branch(3'b101, "br_np_not");
      branch(3'b000, "br_none");
   endtask

   // drives a load table cycle by cycle and collects every strobed value
   task automatic run_loads(input logic [W-1:0] vals[$], input int ncyc, output logic [2:0] got[$]);
      got = {};
      for (int k = 0; k < ncyc; k++) begin
         if (k < vals.size()) begin ld_cc = 1'b1; bus_in = vals[k]; end
         else                 begin ld_cc = 1'b0; bus_in = $urandom; end
         cyc();
         if (cc_write === 1'b0) got.push_back(cc_in);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] v[$];
      logic [2:0]   g[$];
      wait_idle();
      v = {16'h0005, 16'hFFFF};
      run_loads(v, 10, g);
      n_cmp++;
      if (g.size() != 2 || g[0] !== 3'b001 || g[1] !== 3'b100) begin
         n_err++; $display("FAIL back_to_back: got %0d writes %p expected 2 writes 001,100", g.size(), g);
      end
      n_cmp++;
      if (ld_overrun !== 1'b0) begin
         n_err++; $display("FAIL b2b_overrun: ld_overrun=%b expected 0", ld_overrun);
      end
      exp_cc = 3'b100;
   endtask

   task automatic test_overrun();
      logic [W-1:0] v[$];
      logic [2:0]   g[$];
      wait_idle();
      v = {16'h0005, 16'h0000, 16'hFFFF, 16'h0001};
      run_loads(v, 14, g);
      n_cmp++;
      if (g.size() != 3 || g[0] !== 3'b001 || g[1] !== 3'b010 || g[2] !== 3'b100) begin
         n_err++; $display("FAIL overrun_seq: got %0d writes %p expected 3 writes 001,010,100", g.size(), g);
      end
      n_cmp++;
      if (ld_overrun !== 1'b1) begin
         n_err++; $display("FAIL overrun_flag: ld_overrun=%b expected 1", ld_overrun);
      end
      exp_cc = 3'b100;
   endtask

   task automatic test_collide();
      int wr_at, done_at;
      logic [2:0] wr_val;
      logic tk;
      do_reset();
      wr_at = -1; done_at = -1; wr_val = 3'b000; tk = 1'b0;
      ld_cc = 1'b1; br_req = 1'b1; bus_in = 16'h0000; ir_nzp = 3'b010;
      for (int k = 0; k < 10; k++) begin
         cyc();
         ld_cc = 1'b0;
         if (cc_write === 1'b0 && wr_at < 0) begin wr_at = k; wr_val = cc_in; end
         if (br_done === 1'b1 && done_at < 0) begin done_at = k; tk = br_taken; br_req = 1'b0; end
      end
      br_req = 1'b0;
      n_cmp++;
      if (wr_at < 0 || done_at < 0 || wr_at >= done_at || wr_val !== 3'b010 || tk !== 1'b1) begin
         n_err++; $display("FAIL collide: write@%0d=%b done@%0d taken=%b expected write 010 before done, taken 1",
                           wr_at, wr_val, done_at, tk);
      end
      exp_cc = 3'b010;
   endtask

   task automatic test_reset_mid_write();
      int lows;
      wait_idle();
      ld_cc = 1'b1; bus_in = 16'h1234;
      cyc();
      bus_in = 16'h8000;
      cyc();
      ld_cc = 1'b0;
      n_cmp++;
      if (cc_write !== 1'b0) begin
         n_err++; $display("FAIL rst_write_entry: wr=%b expected 0", cc_write);
      end
      reset = 1'b0;
      cyc();
      n_cmp++;
      if ({cc_write, cc_in, busy, br_done} !== {1'b0, 3'b010, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL rst_mid_write: wr=%b cc=%b busy=%b done=%b expected 0 010 1 0",
                           cc_write, cc_in, busy, br_done);
      end
      reset = 1'b1;
      cyc();
      lows = 0;
      for (int k = 0; k < 6; k++) begin
         if (cc_write === 1'b0 || busy !== 1'b0) lows++;
         cyc();
      end
      n_cmp++;
      if (lows != 0) begin
         n_err++; $display("FAIL rst_pend_cleared: %0d active cycles after reset, expected 0", lows);
      end
      exp_cc = 3'b010;
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic [W-1:0] v[$];
      logic [2:0]   g[$];
      int lat;
      do_reset();
      for (int it = 0; it < 40; it++) begin
         a = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         case ($urandom_range(0, 2))
            0: begin
               wait_idle();
               ld_cc = 1'b1; bus_in = a;
               lat = 0;
               do begin
                  cyc(); ld_cc = 1'b0; lat++;
               end while (cc_write !== 1'b0 && lat < 6);
               n_cmp++;
               if (lat != 2 || cc_in !== cls(a)) begin
                  n_err++; $display("FAIL rnd_single: latency %0d cc=%b expected latency 2 cc=%b (bus %h)",
                                    lat, cc_in, cls(a), a);
               end
               exp_cc = cls(a);
            end
            1: begin
               wait_idle();
               v = {a, b};
               run_loads(v, 10, g);
               n_cmp++;
               if (g.size() != 2 || g[0] !== cls(a) || g[1] !== cls(b)) begin
                  n_err++; $display("FAIL rnd_double: got %0d writes %p expected %b,%b", g.size(), g, cls(a), cls(b));
               end
               exp_cc = cls(b);
            end
            default: branch(3'($urandom), "rnd_branch");
         endcase
      end
      wait_idle();
      n_cmp++;
      if ({ld_overrun, ccr_n, ccr_z, ccr_p} !== {1'b0, exp_cc}) begin
         n_err++; $display("FAIL rnd_final: ovr=%b ccr=%b%b%b expected 0 %b", ld_overrun, ccr_n, ccr_z, ccr_p, exp_cc);
      end
   endtask

   initial begin
      reset = 1'b0; ld_cc = 1'b0; br_req = 1'b0; bus_in = '0; ir_nzp = 3'b000;
      exp_cc = 3'b010;
      test_reset();
      test_loads();
      test_branch();
      test_back_to_back();
      test_random();
      test_overrun();
      test_collide();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
